// File: rtl/sram_port_arbiter.sv
// Arbiter sharing one 16-bit asynchronous SRAM between a read/write data port (A)
// and a read-only fetch port (B), with a 4-word I/O window on port A that bypasses SRAM.
module sram_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_BASE     = 16'hBF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic [15:0] a_rdata,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [15:0] b_addr,
    output logic [15:0] b_rdata,
    output logic        b_ack,
    output logic [17:0] mem_addr,
    inout  wire  [15:0] mem_data,
    output logic        mem_en_n,
    output logic        mem_oe_n,
    output logic        mem_we_n
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        b_starved_q, b_starved_d;
    logic        own_b_q, own_b_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [17:0] mem_addr_q, mem_addr_d;
    logic [15:0] a_rdata_q, a_rdata_d;
    logic [15:0] b_rdata_q, b_rdata_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic        mem_en_n_q, mem_en_n_d;
    logic        mem_oe_n_q, mem_oe_n_d;
    logic        mem_we_n_q, mem_we_n_d;
    logic        drive_q, drive_d;

    logic        grant_b;
    logic        a_in_window;
    logic        in_sram_d;

    assign a_in_window = (a_addr[15:2] == IO_BASE[15:2]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_starved_d = b_starved_q;
        own_b_d     = own_b_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        grant_b     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // B overtakes A only when it lost the previous contest
                grant_b = b_req && (!a_req || b_starved_q);
                if (grant_b) begin
                    own_b_d     = 1'b1;
                    we_d        = 1'b0;
                    mem_addr_d  = {2'b00, b_addr};
                    b_starved_d = 1'b0;
                    state_d     = ST_SETUP;
                end else if (a_req) begin
                    own_b_d     = 1'b0;
                    we_d        = a_we;
                    b_starved_d = b_starved_q | b_req;
                    if (a_in_window) begin
                        state_d = ST_DONE;
                        a_ack_d = 1'b1;
                        if (!a_we) begin
                            a_rdata_d = 16'h0000;
                        end
                    end else begin
                        wdata_d    = a_wdata;
                        mem_addr_d = {2'b00, a_addr};
                        state_d    = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (we_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_DONE;
                        if (own_b_q) begin
                            b_rdata_d = mem_data;
                            b_ack_d   = 1'b1;
                        end else begin
                            a_rdata_d = mem_data;
                            a_ack_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_DONE;
                a_ack_d = !own_b_q;
                b_ack_d = own_b_q;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fetch that shows up while A owns the SRAM also counts as having waited
        if ((state_q == ST_SETUP || state_q == ST_ACCESS || state_q == ST_HOLD)
            && !own_b_q && b_req) begin
            b_starved_d = 1'b1;
        end

        // Pin values are derived from the next state so they are registered yet cycle-aligned
        in_sram_d  = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
        mem_en_n_d = !in_sram_d;
        mem_oe_n_d = !(((state_d == ST_SETUP) || (state_d == ST_ACCESS)) && !we_d);
        mem_we_n_d = !((state_d == ST_ACCESS) && we_d);
        drive_d    = in_sram_d && we_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            b_starved_q <= 1'b0;
            own_b_q     <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= 16'h0000;
            mem_addr_q  <= 18'h00000;
            a_rdata_q   <= 16'h0000;
            b_rdata_q   <= 16'h0000;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            mem_en_n_q  <= 1'b1;
            mem_oe_n_q  <= 1'b1;
            mem_we_n_q  <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b_starved_q <= b_starved_d;
            own_b_q     <= own_b_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            mem_en_n_q  <= mem_en_n_d;
            mem_oe_n_q  <= mem_oe_n_d;
            mem_we_n_q  <= mem_we_n_d;
            drive_q     <= drive_d;
        end
    end

    assign mem_data = drive_q ? wdata_q : 16'hzzzz;
    assign mem_addr = mem_addr_q;
    assign mem_en_n = mem_en_n_q;
    assign mem_oe_n = mem_oe_n_q;
    assign mem_we_n = mem_we_n_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: an SRAM device model on the bus plus a transaction-level
// reference (expected memory contents, read-data registers, ack latency and grant order).
module tb_sram_port_arbiter;

    localparam int W    = 2;
    localparam int MAXC = 30;
    localparam logic [15:0] IO_BASE = 16'hBF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0, b_addr = '0;
    logic [15:0] a_rdata, b_rdata;
    logic        a_ack, b_ack;
    logic [17:0] mem_addr;
    wire  [15:0] mem_data;
    logic        mem_en_n, mem_oe_n, mem_we_n;

    int checks = 0;
    int failures = 0;

    sram_port_arbiter #(.WAIT_CYCLES(W), .IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata), .b_ack(b_ack),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_en_n(mem_en_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
    );

    always #5 clk = ~clk;

    // SRAM device: drives the bus on reads, stores on clock edges while WE is low
    logic [15:0] dev_mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0, pre_data = '0;
    logic        dev_drive;
    assign dev_drive = !mem_en_n && !mem_oe_n && mem_we_n;
    assign mem_data  = dev_drive ? dev_mem[mem_addr[15:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (pre_en) dev_mem[pre_addr] <= pre_data;
        else if (!mem_en_n && !mem_we_n) dev_mem[mem_addr[15:0]] <= mem_data;
    end

    // Reference model state
    logic [15:0] ref_mem [0:65535];
    logic [15:0] a_rdata_m = '0, b_rdata_m = '0;

    // Per-transaction observations
    int          tr_ack_cycle, tr_ack_count, tr_other_ack;
    logic [31:0] tr_en_mask, tr_oe_mask, tr_we_mask, tr_bus_mask;
    bit          tr_addr_bad;
    logic [15:0] tr_rdata;

    // Multi-ack observations
    int          ev_port[$];
    int          ev_cycle[$];
    logic [15:0] ev_rdata[$];
    bit          ev_both;

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic bit in_window(input logic [15:0] addr);
        return (addr >= IO_BASE) && (addr <= IO_BASE + 16'd3);
    endfunction

    task automatic preload(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = addr; pre_data = data;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[addr] = data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        a_rdata_m = '0; b_rdata_m = '0;
    endtask

    // Issues one request at a negedge with the DUT idle and records a cycle trace
    task automatic run_single(input bit port_b, input bit we, input logic [15:0] addr,
                              input logic [15:0] wdata, input bit perturb);
        logic [17:0] exp_addr;
        logic        this_ack, other_ack;
        exp_addr = {2'b00, addr};
        tr_ack_cycle = -1; tr_ack_count = 0; tr_other_ack = 0;
        tr_en_mask = '0; tr_oe_mask = '0; tr_we_mask = '0; tr_bus_mask = '0;
        tr_addr_bad = 1'b0; tr_rdata = '0;
        if (port_b) begin b_req = 1'b1; b_addr = addr; end
        else begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
        for (int c = 0; c <= MAXC; c++) begin
            if (c > 0) begin @(posedge clk); @(negedge clk); end
            if (!mem_en_n) tr_en_mask[c] = 1'b1;
            if (!mem_oe_n) tr_oe_mask[c] = 1'b1;
            if (!mem_we_n) tr_we_mask[c] = 1'b1;
            if (mem_data === wdata) tr_bus_mask[c] = 1'b1;
            if (!mem_en_n && mem_addr !== exp_addr) tr_addr_bad = 1'b1;
            this_ack  = port_b ? b_ack : a_ack;
            other_ack = port_b ? a_ack : b_ack;
            if (other_ack) tr_other_ack++;
            if (this_ack) begin
                tr_ack_count++;
                if (tr_ack_cycle < 0) begin
                    tr_ack_cycle = c;
                    tr_rdata = port_b ? b_rdata : a_rdata;
                    a_req = 1'b0; b_req = 1'b0;
                end
            end
            if (perturb && c == 1) begin
                a_req = 1'b0; b_req = 1'b0;
                a_addr = 16'($urandom); b_addr = 16'($urandom); a_wdata = 16'($urandom);
            end
            if (tr_ack_cycle >= 0 && c >= tr_ack_cycle + 2) break;
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    // Observes acks while requests are held; requests drop once n acks are seen
    task automatic record_acks(input int n, input int b_rise_cycle, input logic [15:0] b_rise_addr);
        ev_port.delete(); ev_cycle.delete(); ev_rdata.delete(); ev_both = 1'b0;
        for (int c = 0; c <= 80; c++) begin
            if (c > 0) begin @(posedge clk); @(negedge clk); end
            if (c == b_rise_cycle) begin b_req = 1'b1; b_addr = b_rise_addr; end
            if (a_ack && b_ack) ev_both = 1'b1;
            if (a_ack) begin ev_port.push_back(0); ev_cycle.push_back(c); ev_rdata.push_back(a_rdata); end
            if (b_ack) begin ev_port.push_back(1); ev_cycle.push_back(c); ev_rdata.push_back(b_rdata); end
            if (ev_port.size() >= n) begin a_req = 1'b0; b_req = 1'b0; end
            if (ev_port.size() >= n && c >= ev_cycle[n-1] + 2) break;
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_en_n, mem_oe_n, mem_we_n} !== 3'b111) begin
            failures++; $display("FAIL reset_ctrl got %b exp 111", {mem_en_n, mem_oe_n, mem_we_n});
        end
        checks++;
        if ({a_ack, b_ack} !== 2'b00 || a_rdata !== 16'h0 || b_rdata !== 16'h0 || mem_addr !== 18'h0) begin
            failures++; $display("FAIL reset_outs got ack=%b a_rd=%h b_rd=%h addr=%h exp 0",
                                 {a_ack, b_ack}, a_rdata, b_rdata, mem_addr);
        end
        rst = 1'b1;
    endtask

    task automatic test_b_read();
        preload(16'h0100, 16'h1234);
        @(negedge clk);
        run_single(1'b1, 1'b0, 16'h0100, 16'h0001, 1'b0);
        b_rdata_m = ref_mem[16'h0100];
        checks++;
        if (tr_ack_cycle != W + 2 || tr_ack_count != 1 || tr_other_ack != 0) begin
            failures++; $display("FAIL b_read_ack got cyc=%0d cnt=%0d other=%0d exp cyc=%0d cnt=1 other=0",
                                 tr_ack_cycle, tr_ack_count, tr_other_ack, W + 2);
        end
        checks++;
        if (tr_oe_mask !== rng(1, W + 1) || tr_en_mask !== rng(1, W + 1) || tr_we_mask !== 32'h0) begin
            failures++; $display("FAIL b_read_pins got oe=%h en=%h we=%h exp oe/en=%h we=0",
                                 tr_oe_mask, tr_en_mask, tr_we_mask, rng(1, W + 1));
        end
        checks++;
        if (tr_addr_bad || tr_rdata !== 16'h1234 || b_rdata !== b_rdata_m) begin
            failures++; $display("FAIL b_read_data got addr_bad=%0d rdata=%h hold=%h exp 0 1234 1234",
                                 tr_addr_bad, tr_rdata, b_rdata);
        end
    endtask

    task automatic test_a_write();
        run_single(1'b0, 1'b1, 16'h0200, 16'hBEEF, 1'b0);
        ref_mem[16'h0200] = 16'hBEEF;
        checks++;
        if (tr_ack_cycle != W + 3 || tr_ack_count != 1) begin
            failures++; $display("FAIL a_write_ack got cyc=%0d cnt=%0d exp cyc=%0d cnt=1",
                                 tr_ack_cycle, tr_ack_count, W + 3);
        end
        checks++;
        if (tr_we_mask !== rng(2, W + 1) || tr_en_mask !== rng(1, W + 2) || tr_oe_mask !== 32'h0) begin
            failures++; $display("FAIL a_write_pins got we=%h en=%h oe=%h exp we=%h en=%h oe=0",
                                 tr_we_mask, tr_en_mask, tr_oe_mask, rng(2, W + 1), rng(1, W + 2));
        end
        checks++;
        if (tr_bus_mask !== rng(1, W + 2) || tr_addr_bad) begin
            failures++; $display("FAIL a_write_bus got drive=%h addr_bad=%0d exp drive=%h",
                                 tr_bus_mask, tr_addr_bad, rng(1, W + 2));
        end
        run_single(1'b0, 1'b0, 16'h0200, 16'h0001, 1'b0);
        a_rdata_m = ref_mem[16'h0200];
        checks++;
        if (tr_ack_cycle != W + 2 || a_rdata !== a_rdata_m || b_rdata !== b_rdata_m) begin
            failures++; $display("FAIL a_readback got cyc=%0d a_rd=%h b_rd=%h exp cyc=%0d a_rd=%h b_rd=%h",
                                 tr_ack_cycle, a_rdata, b_rdata, W + 2, a_rdata_m, b_rdata_m);
        end
    endtask

    task automatic test_reset_mid_write();
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0300; a_wdata = 16'hA5A5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_we_n !== 1'b0) begin
            failures++; $display("FAIL pre_reset_we got %b exp 0", mem_we_n);
        end
        #1 rst = 1'b0; a_req = 1'b0;
        #1;
        checks++;
        if ({mem_en_n, mem_oe_n, mem_we_n} !== 3'b111 || mem_data === 16'hA5A5) begin
            failures++; $display("FAIL async_reset got ctrl=%b bus=%h exp ctrl=111 bus released",
                                 {mem_en_n, mem_oe_n, mem_we_n}, mem_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
                failures++; $display("FAIL reset_no_ack got a=%b b=%b exp 0 0", a_ack, b_ack);
            end
        end
        rst = 1'b1;
        a_rdata_m = '0; b_rdata_m = '0;
        checks++;
        if (a_rdata !== a_rdata_m || b_rdata !== b_rdata_m) begin
            failures++; $display("FAIL reset_rdata got a=%h b=%h exp 0 0", a_rdata, b_rdata);
        end
        @(negedge clk);
        run_single(1'b1, 1'b0, 16'h0100, 16'h0001, 1'b0);
        b_rdata_m = ref_mem[16'h0100];
        checks++;
        if (tr_ack_cycle != W + 2 || b_rdata !== b_rdata_m) begin
            failures++; $display("FAIL post_reset_idle got cyc=%0d b_rd=%h exp cyc=%0d b_rd=%h",
                                 tr_ack_cycle, b_rdata, W + 2, b_rdata_m);
        end
    endtask

    task automatic test_window();
        run_single(1'b0, 1'b1, 16'hBF01, 16'h7E57, 1'b0);
        checks++;
        if (tr_ack_cycle != 1 || tr_en_mask !== 32'h0 || tr_we_mask !== 32'h0 || a_rdata !== a_rdata_m) begin
            failures++; $display("FAIL window_write got cyc=%0d en=%h we=%h a_rd=%h exp cyc=1 en=0 we=0 a_rd=%h",
                                 tr_ack_cycle, tr_en_mask, tr_we_mask, a_rdata, a_rdata_m);
        end
        run_single(1'b0, 1'b0, 16'hBF02, 16'h0001, 1'b0);
        a_rdata_m = 16'h0000;
        checks++;
        if (tr_ack_cycle != 1 || tr_en_mask !== 32'h0 || a_rdata !== a_rdata_m) begin
            failures++; $display("FAIL window_read got cyc=%0d en=%h a_rd=%h exp cyc=1 en=0 a_rd=0",
                                 tr_ack_cycle, tr_en_mask, a_rdata);
        end
        run_single(1'b0, 1'b0, 16'hBEFF, 16'h0001, 1'b0);
        a_rdata_m = ref_mem[16'hBEFF];
        checks++;
        if (tr_ack_cycle != W + 2 || tr_en_mask !== rng(1, W + 1) || a_rdata !== a_rdata_m || tr_addr_bad) begin
            failures++; $display("FAIL below_window got cyc=%0d en=%h a_rd=%h exp cyc=%0d en=%h a_rd=%h",
                                 tr_ack_cycle, tr_en_mask, a_rdata, W + 2, rng(1, W + 1), a_rdata_m);
        end
    endtask

    task automatic test_drop_and_change();
        run_single(1'b1, 1'b0, 16'h0110, 16'h0001, 1'b1);
        b_rdata_m = ref_mem[16'h0110];
        checks++;
        if (tr_ack_cycle != W + 2 || tr_ack_count != 1 || tr_addr_bad || b_rdata !== b_rdata_m) begin
            failures++; $display("FAIL drop_change got cyc=%0d cnt=%0d addr_bad=%0d b_rd=%h exp cyc=%0d cnt=1 0 %h",
                                 tr_ack_cycle, tr_ack_count, tr_addr_bad, b_rdata, W + 2, b_rdata_m);
        end
    endtask

    task automatic test_back_to_back();
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1004;
        record_acks(3, -1, 16'h0);
        checks++;
        if (ev_port.size() != 3) begin
            failures++; $display("FAIL b2b_count got %0d exp 3", ev_port.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ev_port[i] != 0 || ev_cycle[i] != (W + 2) + i * (W + 3) || ev_rdata[i] !== ref_mem[16'h1004]) begin
                    failures++; $display("FAIL b2b_%0d got port=%0d cyc=%0d rd=%h exp port=0 cyc=%0d rd=%h",
                                         i, ev_port[i], ev_cycle[i], ev_rdata[i], (W + 2) + i * (W + 3), ref_mem[16'h1004]);
                end
            end
        end
    endtask

    task automatic test_conflict();
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1000;
        b_req = 1'b1; b_addr = 16'h1001;
        record_acks(4, -1, 16'h0);
        checks++;
        if (ev_port.size() != 4 || ev_both) begin
            failures++; $display("FAIL conflict_count got %0d both=%0d exp 4 0", ev_port.size(), ev_both);
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [15:0] exp_rd;
                exp_rd = (i % 2 == 0) ? ref_mem[16'h1000] : ref_mem[16'h1001];
                checks++;
                if (ev_port[i] != i % 2 || ev_cycle[i] != (W + 2) + i * (W + 3) || ev_rdata[i] !== exp_rd) begin
                    failures++; $display("FAIL conflict_%0d got port=%0d cyc=%0d rd=%h exp port=%0d cyc=%0d rd=%h",
                                         i, ev_port[i], ev_cycle[i], ev_rdata[i], i % 2, (W + 2) + i * (W + 3), exp_rd);
                end
            end
        end
    endtask

    task automatic test_starve_mid_access();
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1002;
        record_acks(2, 2, 16'h1003);
        checks++;
        if (ev_port.size() != 2 || ev_port[0] != 0 || ev_port[1] != 1 || ev_cycle[1] != (W + 2) + (W + 3)) begin
            failures++; $display("FAIL starve_mid got n=%0d order=%0d%0d cyc=%0d exp n=2 order=01 cyc=%0d",
                                 ev_port.size(), (ev_port.size() > 0) ? ev_port[0] : -1,
                                 (ev_port.size() > 1) ? ev_port[1] : -1,
                                 (ev_cycle.size() > 1) ? ev_cycle[1] : -1, (W + 2) + (W + 3));
        end
        a_rdata_m = ref_mem[16'h1002];
        b_rdata_m = ref_mem[16'h1003];
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit          pb, we, win, pert;
            logic [15:0] addr, wdata;
            int          exp_cyc;
            logic [31:0] exp_en;
            pb   = 1'($urandom);
            we   = pb ? 1'b0 : 1'($urandom);
            addr = (!pb && $urandom_range(0, 7) == 0) ? (IO_BASE + 16'($urandom_range(0, 3)))
                                                      : (16'h1000 + 16'($urandom_range(0, 63)));
            wdata = 16'($urandom) | 16'h0001;
            pert  = ($urandom_range(0, 3) == 0);
            win   = !pb && in_window(addr);
            exp_cyc = win ? 1 : (we ? W + 3 : W + 2);
            exp_en  = win ? 32'h0 : (we ? rng(1, W + 2) : rng(1, W + 1));
            run_single(pb, we, addr, wdata, pert);
            if (!we) begin
                if (pb) b_rdata_m = ref_mem[addr];
                else    a_rdata_m = win ? 16'h0000 : ref_mem[addr];
            end else if (!win) begin
                ref_mem[addr] = wdata;
            end
            checks++;
            if (tr_ack_cycle != exp_cyc || tr_ack_count != 1 || tr_other_ack != 0 || tr_en_mask !== exp_en || tr_addr_bad) begin
                failures++; $display("FAIL rand_%0d_timing got cyc=%0d cnt=%0d other=%0d en=%h bad=%0d exp cyc=%0d en=%h",
                                     n, tr_ack_cycle, tr_ack_count, tr_other_ack, tr_en_mask, tr_addr_bad, exp_cyc, exp_en);
            end
            checks++;
            if (a_rdata !== a_rdata_m || b_rdata !== b_rdata_m) begin
                failures++; $display("FAIL rand_%0d_data got a=%h b=%h exp a=%h b=%h",
                                     n, a_rdata, b_rdata, a_rdata_m, b_rdata_m);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        for (int i = 0; i < 64; i++) preload(16'h1000 + 16'(i), 16'($urandom));
        preload(16'h0110, 16'h0110 ^ 16'h5A5A);
        preload(16'hBEFF, 16'hC0DE);
        test_b_read();
        test_a_write();
        test_reset_mid_write();
        test_window();
        test_drop_and_change();
        test_back_to_back();
        test_conflict();
        test_starve_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
